// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives PLL reset, waits for stable lock, releases sys_rst.
// Optional RUN lock-loss glitch filter enabled by defining PLL_LOCK_FILTER_EN.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 20
`ifdef PLL_LOCK_FILTER_EN
  ,
  parameter int GLITCH_CYCLES = 4
`endif
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clr_stats,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    ASSERT,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       relock_nxt;
  logic             loss;
  logic             drop;
  logic             lk_m;
  logic             lk_s;

`ifdef PLL_LOCK_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GLITCH_CYCLES - 1);

  logic [GW-1:0] gcnt;
  logic [GW-1:0] gcnt_nxt;

  // RUN lock loss acts only on the GLITCH_CYCLES-th consecutive low cycle
  always_comb begin
    drop     = 1'b0;
    gcnt_nxt = '0;
    if (state == RUN && !lk_s) begin
      if (gcnt == G_LAST) begin
        drop = 1'b1;
      end else begin
        gcnt_nxt = gcnt + 1'b1;
      end
    end
  end

  // Glitch filter counter
  always_ff @(posedge refclk) begin
    if (rst) begin
      gcnt <= '0;
    end else begin
      gcnt <= gcnt_nxt;
    end
  end
`else
  // Any low synchronized lock cycle in RUN is a loss
  always_comb begin
    drop = !lk_s;
  end
`endif

  // Two-flop synchronizer for the asynchronous lock indicator
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= pll_locked;
      lk_s <= lk_m;
    end
  end

  // Next state, shared counter and retry bookkeeping
  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt + 1'b1;
    retry_nxt = retry_cnt;
    loss      = 1'b0;
    unique case (state)
      ASSERT: begin
        if (cnt == RST_LAST) begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          nxt     = STABLE;
          cnt_nxt = '0;
        end else if (cnt == TMO_LAST) begin
          cnt_nxt = '0;
          if (retry_cnt == RETRY_MAX) begin
            nxt = FAULT;
          end else begin
            nxt       = ASSERT;
            retry_nxt = retry_cnt + 1'b1;
          end
        end
      end
      STABLE: begin
        if (!lk_s) begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == STB_LAST) begin
          nxt       = RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (drop) begin
          nxt  = ASSERT;
          loss = 1'b1;
        end
      end
      FAULT: begin
        cnt_nxt = '0;
      end
      default: begin
        nxt     = ASSERT;
        cnt_nxt = '0;
      end
    endcase
  end

  // Lock-loss statistics: clear beats a coincident increment
  always_comb begin
    relock_nxt = relock_cnt;
    if (clr_stats) begin
      relock_nxt = '0;
    end else if (loss && relock_cnt != 8'hFF) begin
      relock_nxt = relock_cnt + 1'b1;
    end
  end

  // State register with outputs decoded from the next state
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= ASSERT;
      cnt        <= '0;
      retry_cnt  <= '0;
      relock_cnt <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      retry_cnt  <= retry_nxt;
      relock_cnt <= relock_nxt;
      pll_rst    <= (nxt == ASSERT) || (nxt == FAULT);
      sys_rst    <= (nxt != RUN);
      ready      <= (nxt == RUN);
      fault      <= (nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer.
// Bench parameters: RST=4, TIMEOUT=100, STABLE=16, MAX_RETRY=2.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clr_stats = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] relock_cnt;

  int checks = 0;
  int failures = 0;

`ifdef PLL_LOCK_FILTER_EN
  localparam int REACT = 6;
`else
  localparam int REACT = 3;
`endif

  localparam logic [15:0] RST_VEC = 16'b1100_0000_0000_0000;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(100),
    .STABLE_CYCLES(16),
    .MAX_RETRY(2),
    .CNT_W(20)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .clr_stats(clr_stats),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .relock_cnt(relock_cnt)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int lim, output int n);
    n = 0;
    while (ready !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic do_loss(output bit ok);
    int n;
    ok = 1'b1;
    pll_locked = 1'b0;
    n = 0;
    while (ready === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ready !== 1'b0) ok = 1'b0;
    pll_locked = 1'b1;
    wait_ready(100, n);
    if (ready !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    tick();
    v = {pll_rst, sys_rst, ready, fault, retry_cnt, relock_cnt};
    checks++;
    if (v !== RST_VEC) begin
      failures++;
      $display("FAIL reset_vals: got %b required %b", v, RST_VEC);
    end
  endtask

  task automatic test_normal();
    int n;
    pll_locked = 1'b0;
    do_reset();
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL pll_rst_len: got %0d required 4", n);
    end
    repeat (20) tick();
    checks++;
    if ({pll_rst, sys_rst} !== 2'b01) begin
      failures++;
      $display("FAIL wait_lock_outs: got %b required 01",
               {pll_rst, sys_rst});
    end
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 19) begin
      failures++;
      $display("FAIL sys_rst_delay: got %0d required 19", n);
    end
    checks++;
    if ({ready, fault, pll_rst, retry_cnt} !== 7'b100_0000) begin
      failures++;
      $display("FAIL run_outs: got %b required 1000000",
               {ready, fault, pll_rst, retry_cnt});
    end
  endtask

  task automatic test_timeout_fault();
    int n;
    int runlen;
    int falls;
    int badlen;
    int sysbad;
    logic prev;
    pll_locked = 1'b0;
    do_reset();
    runlen = 1;
    falls = 0;
    badlen = 0;
    sysbad = 0;
    n = 0;
    while (fault !== 1'b1 && n < 400) begin
      prev = pll_rst;
      tick();
      n++;
      if (sys_rst !== 1'b1) sysbad++;
      if (pll_rst === 1'b1) begin
        runlen++;
      end else begin
        if (prev === 1'b1) begin
          falls++;
          if (runlen != 4) badlen++;
        end
        runlen = 0;
      end
    end
    checks++;
    if (n != 312) begin
      failures++;
      $display("FAIL fault_time: got %0d required 312", n);
    end
    checks++;
    if (falls != 3 || badlen != 0) begin
      failures++;
      $display("FAIL rst_pulses: got %0d bad=%0d required 3 bad=0",
               falls, badlen);
    end
    checks++;
    if (sysbad != 0) begin
      failures++;
      $display("FAIL sys_rst_held: got %0d low cycles required 0",
               sysbad);
    end
    checks++;
    if ({retry_cnt, pll_rst, ready} !== 6'b0010_10) begin
      failures++;
      $display("FAIL fault_outs: got %b required 001010",
               {retry_cnt, pll_rst, ready});
    end
    pll_locked = 1'b1;
    repeat (50) tick();
    checks++;
    if ({fault, ready, sys_rst} !== 3'b101) begin
      failures++;
      $display("FAIL fault_terminal: got %b required 101",
               {fault, ready, sys_rst});
    end
  endtask

  task automatic test_stable_glitch();
    int n;
    logic [3:0] r;
    pll_locked = 1'b0;
    do_reset();
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (pll_rst === 1'b0 && n < 200) begin
      tick();
      n++;
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (retry_cnt !== 4'd1 || pll_rst !== 1'b0) begin
      failures++;
      $display("FAIL retry_setup: got %0d/%b required 1/0",
               retry_cnt, pll_rst);
    end
    pll_locked = 1'b1;
    repeat (11) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    n = 12;
    r = 4'hF;
    while (sys_rst === 1'b1 && n < 80) begin
      tick();
      n++;
      if (n == 20) r = retry_cnt;
    end
    checks++;
    if (n != 31) begin
      failures++;
      $display("FAIL stable_restart: got %0d required 31", n);
    end
    checks++;
    if (r !== 4'd1) begin
      failures++;
      $display("FAIL stable_retry: got %0d required 1", r);
    end
    checks++;
    if (ready !== 1'b1 || retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL stable_run: got %b/%0d required 1/0",
               ready, retry_cnt);
    end
  endtask

  task automatic test_run_loss();
    int first;
    int n;
    logic sr;
`ifdef PLL_LOCK_FILTER_EN
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    checks++;
    if ({ready, pll_rst, relock_cnt} !== 10'b10_0000_0000) begin
      failures++;
      $display("FAIL filter_short: got %b required 1000000000",
               {ready, pll_rst, relock_cnt});
    end
`endif
    pll_locked = 1'b0;
    first = 0;
    sr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (first == 0 && pll_rst === 1'b1) begin
        first = i;
        sr = sys_rst;
      end
      if (i == 5) pll_locked = 1'b1;
    end
    checks++;
    if (first != REACT || sr !== 1'b1) begin
      failures++;
      $display("FAIL loss_react: got %0d/%b required %0d/1",
               first, sr, REACT);
    end
    checks++;
    if (relock_cnt !== 8'd1) begin
      failures++;
      $display("FAIL relock_one: got %0d required 1", relock_cnt);
    end
    wait_ready(100, n);
    checks++;
    if (ready !== 1'b1 || retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL loss_recover: got %b/%0d required 1/0",
               ready, retry_cnt);
    end
  endtask

  task automatic test_clr_stats();
    bit ok;
    int bad;
    int n;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      do_loss(ok);
      if (!ok) bad++;
    end
    checks++;
    if (relock_cnt !== 8'd7 || bad != 0) begin
      failures++;
      $display("FAIL relock_seven: got %0d bad=%0d required 7 bad=0",
               relock_cnt, bad);
    end
    pll_locked = 1'b0;
    repeat (REACT - 1) tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (ready !== 1'b0 || relock_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_wins: got %b/%0d required 0/0",
               ready, relock_cnt);
    end
    pll_locked = 1'b1;
    wait_ready(100, n);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      do_loss(ok);
      if (!ok) bad++;
    end
    checks++;
    if (relock_cnt !== 8'd255 || bad != 0) begin
      failures++;
      $display("FAIL relock_255: got %0d bad=%0d required 255 bad=0",
               relock_cnt, bad);
    end
    do_loss(ok);
    checks++;
    if (relock_cnt !== 8'd255 || !ok) begin
      failures++;
      $display("FAIL relock_sat: got %0d ok=%0d required 255 ok=1",
               relock_cnt, ok);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    logic [15:0] v;
    pll_locked = 1'b0;
    n = 0;
    while (pll_rst !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    repeat (10) tick();
    rst = 1'b1;
    tick();
    v = {pll_rst, sys_rst, ready, fault, retry_cnt, relock_cnt};
    checks++;
    if (v !== RST_VEC) begin
      failures++;
      $display("FAIL wait_rst_vals: got %b required %b", v, RST_VEC);
    end
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL wait_rst_pulse: got %0d required 4", n);
    end
    n = 0;
    while (fault !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (fault !== 1'b1 || retry_cnt !== 4'd2) begin
      failures++;
      $display("FAIL reach_fault: got %b/%0d required 1/2",
               fault, retry_cnt);
    end
    rst = 1'b1;
    tick();
    v = {pll_rst, sys_rst, ready, fault, retry_cnt, relock_cnt};
    checks++;
    if (v !== RST_VEC) begin
      failures++;
      $display("FAIL fault_rst_vals: got %b required %b", v, RST_VEC);
    end
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL fault_rst_pulse: got %0d required 4", n);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout_fault();
    test_stable_glitch();
    test_run_loss();
    test_clr_stats();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
